trap_sequencer: RTL

- Sequences the pipeline response to a trap from the trap detector: captures trap PC and cause, flushes the pipe for a fixed number of cycles, then redirects fetch to the handler vector.
- Handles return from the handler on mret by redirecting to the saved PC.
- A trap raised while already in the handler is a double fault and halts the core.
- Sits between the trap detector and the fetch/pipeline-control logic of the RV32I core.

---
 rtl/trap_pkg.sv | 16 +
 rtl/trap_flush_counter.sv | 21 ++
 rtl/trap_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, cause codes and cause width for the trap sequencer
package trap_pkg;
    localparam int CAUSE_W = 3;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4,
        HALT     = 3'd5
    } state_e;
    localparam logic [CAUSE_W-1:0] NONE        = 3'd0;
    localparam logic [CAUSE_W-1:0] MEM_ACCESS  = 3'd1;
    localparam logic [CAUSE_W-1:0] ILLEGAL     = 3'd2;
    localparam logic [CAUSE_W-1:0] INST_ACCESS = 3'd3;
endpackage

// File: rtl/trap_flush_counter.sv
// trap_flush_counter: loadable down-counter with zero flag for timing pipeline drains
module trap_flush_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // Load wins over decrement; decrement stops at zero
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: trap capture, pipeline flush, handler redirect, mret return and double-fault halt.
// Optional TRAP_STATS_EN adds a saturating trap_count output.
module trap_sequencer #(
    parameter int XLEN         = 32,
    parameter int CAUSE_W      = trap_pkg::CAUSE_W,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_req,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic [XLEN-1:0]    trap_vec,
    input  logic               mret,
    input  logic               redirect_ack,
    output logic               flush,
    output logic               stall,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    mepc,
    output logic [CAUSE_W-1:0] mcause,
    output logic               in_handler,
`ifdef TRAP_STATS_EN
    output logic [15:0]        trap_count,
`endif
    output logic               double_fault
);
    import trap_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_e             state_q, state_d;
    logic               trap_req_q, trap_ev, cnt_zero;
    logic [XLEN-1:0]    mepc_q, mepc_d, vec_q, vec_d;
    logic [CAUSE_W-1:0] mcause_q, mcause_d;
    logic               df_q, df_d;

    assign trap_ev = trap_req & ~trap_req_q & (trap_cause != CAUSE_W'(NONE));

    trap_flush_counter #(.W(4)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == IDLE && trap_ev),
        .dec_i  (state_q == FLUSH),
        .val_i  (CNT_INIT),
        .zero_o (cnt_zero)
    );

    // Next-state and capture logic; trap beats mret in HANDLER, unknown states fall into HALT
    always_comb begin
        state_d  = state_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        vec_d    = vec_q;
        df_d     = df_q;
        case (state_q)
            IDLE: if (trap_ev) begin
                mepc_d   = trap_pc;
                mcause_d = trap_cause;
                vec_d    = trap_vec;
                state_d  = FLUSH;
            end
            FLUSH:    if (cnt_zero) state_d = REDIRECT;
            REDIRECT: if (redirect_ack) state_d = HANDLER;
            HANDLER: if (trap_ev) begin
                state_d = HALT;
                df_d    = 1'b1;
            end else if (mret) state_d = RETURN;
            RETURN: if (redirect_ack) begin
                mcause_d = '0;
                state_d  = IDLE;
            end
            default: state_d = HALT;
        endcase
    end

    // State and captured trap context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            trap_req_q <= 1'b0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            vec_q      <= '0;
            df_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            trap_req_q <= trap_req;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            vec_q      <= vec_d;
            df_q       <= df_d;
        end
    end

    assign flush          = (state_q == FLUSH) || (state_q == RETURN);
    assign stall          = (state_q == FLUSH) || (state_q == REDIRECT) || (state_q == RETURN) || (state_q == HALT);
    assign redirect_valid = (state_q == REDIRECT) || (state_q == RETURN);
    assign redirect_pc    = (state_q == REDIRECT) ? vec_q : (state_q == RETURN) ? mepc_q : '0;
    assign in_handler     = (state_q == HANDLER);
    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign double_fault   = df_q;

`ifdef TRAP_STATS_EN
    logic [15:0] trap_count_q;
    logic        trap_acc;
    assign trap_acc = trap_ev && (state_q == IDLE || state_q == HANDLER);
    // Saturating count of accepted trap events
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   trap_count_q <= '0;
        else if (trap_acc && trap_count_q != 16'hFFFF) trap_count_q <= trap_count_q + 1'b1;
    end
    assign trap_count = trap_count_q;
`endif
endmodule
